// File: rtl/q_sys_pio_pkg.sv
// rtl/q_sys_pio_pkg.sv - shared register map and edge encodings for q_sys PIO blocks
package q_sys_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  function automatic logic [31:0] detect_edges(input logic [31:0] cur,
                                               input logic [31:0] prev,
                                               input int          kind);
    case (kind)
      EDGE_FALLING: return ~cur & prev;
      EDGE_ANY:     return cur ^ prev;
      default:      return cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/q_sys_bit_sync.sv
// rtl/q_sys_bit_sync.sv - multi-bit flop-chain synchronizer for asynchronous inputs
module q_sys_bit_sync #(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/q_sys_in_port_capture.sv
// rtl/q_sys_in_port_capture.sv - input PIO with per-bit edge capture, W1C clear and masked irq
module q_sys_in_port_capture
  import q_sys_pio_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0]   data_in;
  logic [WIDTH-1:0]   prev_in;
  logic [WIDTH-1:0]   edge_capture;
  logic [WIDTH-1:0]   irqmask;
  logic [WIDTH-1:0]   edge_bits;
  logic [WIDTH-1:0]   clr_bits;
  logic [31:0]        edge_all;
  logic [31:0]        rd_mux;
  logic [SYNC_STAGES:0] armed;
  logic               wr;
  logic               unused_bits;

  q_sys_bit_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (in_port),
    .q      (data_in)
  );

  assign wr       = chipselect & ~write_n;
  assign edge_all = detect_edges(32'(data_in), 32'(prev_in), EDGE_TYPE);

  // Edges stay masked until both data_in and prev_in hold real post-reset samples,
  // so an input already high during reset is not reported as a rising edge.
  assign edge_bits = armed[SYNC_STAGES] ? edge_all[WIDTH-1:0] : '0;
  assign clr_bits  = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  assign unused_bits = ^{edge_all, writedata};

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = data_in;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_in      <= '0;
      armed        <= '0;
      edge_capture <= '0;
      irqmask      <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      prev_in <= data_in;
      armed   <= {armed[SYNC_STAGES-1:0], 1'b1};
      if (wr && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
      // A fresh edge overrides a simultaneous clear of the same bit.
      edge_capture <= edge_bits | (edge_capture & ~clr_bits);
      irq          <= |(edge_capture & irqmask);
      readdata     <= rd_mux;
    end
  end

endmodule

// File: tb/tb_q_sys_in_port_capture.sv
// tb/tb_q_sys_in_port_capture.sv - directed bench for rising-edge and any-edge input PIO instances
module tb_q_sys_in_port_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [9:0]  in_r;
  logic [9:0]  in_a;
  logic [31:0] readdata_r;
  logic [31:0] readdata_a;
  logic        irq_r;
  logic        irq_a;
  logic [31:0] rd_r;
  logic [31:0] rd_a;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  q_sys_in_port_capture #(.WIDTH(10), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_r (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_r),
    .readdata  (readdata_r),
    .irq       (irq_r)
  );

  q_sys_in_port_capture #(.WIDTH(10), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_a),
    .readdata  (readdata_a),
    .irq       (irq_a)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] r, output logic [31:0] a);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick(1);
    r          = readdata_r;
    a          = readdata_a;
    chipselect = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_r       = 10'h3FF;
    in_a       = 10'h000;

    tick(3);
    check("reset_readdata", readdata_r, 32'h0);
    check("reset_irq", {31'b0, irq_r}, 32'h0);
    reset_n = 1'b1;
    tick(4);
    bus_read(2'd0, rd_r, rd_a);
    check("data_after_reset", rd_r, 32'h0000_03FF);
    bus_read(2'd3, rd_r, rd_a);
    check("no_spurious_edge", rd_r, 32'h0);

    bus_write(2'd2, 32'h0000_0004);
    in_r = 10'h3FB;
    tick(5);
    bus_read(2'd3, rd_r, rd_a);
    check("falling_not_captured", rd_r, 32'h0);
    in_r = 10'h3FF;
    tick(3);
    check("irq_not_yet", {31'b0, irq_r}, 32'h0);
    tick(1);
    check("irq_latency", {31'b0, irq_r}, 32'h1);
    bus_read(2'd3, rd_r, rd_a);
    check("rising_capture", rd_r, 32'h4);
    in_r = 10'h3FB;
    tick(5);
    bus_read(2'd3, rd_r, rd_a);
    check("fall_no_new_capture", rd_r, 32'h4);

    in_r = 10'h3FA;
    tick(5);
    in_r = 10'h3FB;
    tick(5);
    bus_read(2'd3, rd_r, rd_a);
    check("capture_5", rd_r, 32'h5);
    bus_write(2'd3, 32'h0000_0001);
    bus_read(2'd3, rd_r, rd_a);
    check("w1c_bit0", rd_r, 32'h4);
    check("irq_held", {31'b0, irq_r}, 32'h1);
    bus_write(2'd3, 32'h0000_0004);
    check("irq_lags_clear", {31'b0, irq_r}, 32'h1);
    tick(1);
    check("irq_deassert", {31'b0, irq_r}, 32'h0);
    bus_read(2'd3, rd_r, rd_a);
    check("capture_cleared", rd_r, 32'h0);

    in_r = 10'h3FA;
    tick(5);
    in_r = 10'h3FB;
    tick(2);
    bus_write(2'd3, 32'h0000_0001);
    bus_read(2'd3, rd_r, rd_a);
    check("set_wins", rd_r, 32'h1);

    bus_write(2'd2, 32'h0);
    in_a = 10'h200;
    tick(3);
    in_a = 10'h000;
    tick(6);
    bus_read(2'd3, rd_r, rd_a);
    check("any_edge_capture", rd_a, 32'h200);
    check("masked_irq", {31'b0, irq_a}, 32'h0);
    bus_write(2'd2, 32'h0000_0200);
    check("irq_mask_lag", {31'b0, irq_a}, 32'h0);
    tick(1);
    check("irq_unmasked", {31'b0, irq_a}, 32'h1);
    bus_read(2'd2, rd_r, rd_a);
    check("irqmask_readback", rd_a, 32'h200);

    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("irq_after_reset", {31'b0, irq_a}, 32'h0);
    bus_read(2'd0, rd_r, rd_a);
    check("data_after_midreset", rd_r, 32'h0);
    bus_read(2'd1, rd_r, rd_a);
    check("reserved_reads_0", rd_a, 32'h0);
    bus_read(2'd2, rd_r, rd_a);
    check("mask_after_midreset", rd_a, 32'h0);
    bus_read(2'd3, rd_r, rd_a);
    check("capture_after_midreset", rd_a, 32'h0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, rd_r, rd_a);
    check("mask_upper_bits", rd_r, 32'h0000_03FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
